// File: rtl/sync_fifo.sv
// Single-clock FIFO with an arbitrary (non power-of-two) depth, threshold flags and sticky error flags.
// Latency: FWFT=1 presents the head entry combinationally; FWFT=0 returns data one cycle after an accepted read.
// Backpressure: writes are dropped while full_o is high and reads are ignored while empty_o is high; both set an error flag.
module sync_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  empty_o,
  output logic                  not_empty_o,
  output logic                  almost_empty_o,
  output logic [PTR_WIDTH:0]    count_o,
  input  logic                  flush_i,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clr_err_i
);

  localparam logic [PTR_WIDTH:0]   DEPTH_CNT = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   AF_CNT    = (PTR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0]   AE_CNT    = (PTR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q;
  logic [PTR_WIDTH-1:0]  rd_ptr_q;
  logic [PTR_WIDTH:0]    count_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;
  logic ovf_set;
  logic unf_set;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // Status is decoded from the registered occupancy only, never from the request inputs.
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  assign full_o         = full;
  assign almost_full_o  = (count_q >= AF_CNT);
  assign empty_o        = empty;
  assign not_empty_o    = ~empty;
  assign almost_empty_o = (count_q <= AE_CNT);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  // Flush wins over both requests; a full FIFO still accepts a read, an empty one still accepts a write.
  assign wr_acc = wr_en_i & ~full  & ~flush_i;
  assign rd_acc = rd_en_i & ~empty & ~flush_i;

  // A write at full paired with a read is not flagged: the read frees the slot the producer is retrying for.
  assign ovf_set = wr_en_i & full & ~rd_en_i;
  assign unf_set = rd_en_i & empty;

  // Pointer and occupancy update; reset and flush both return to an empty FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (rd_acc) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_set | (overflow_q  & ~clr_err_i);
      underflow_q <= unf_set | (underflow_q & ~clr_err_i);
    end
  end

  // Storage array is deliberately not reset; a write coinciding with reset is discarded.
  always_ff @(posedge clk_i) begin
    if (rst_i && wr_acc) mem[wr_ptr_q] <= wr_data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is visible as soon as the FIFO is non-empty.
      assign rd_data_o  = mem[rd_ptr_q];
      assign rd_valid_o = ~empty;
    end else begin : g_reg_rd
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      // Registered read port: capture the head on an accepted read, otherwise hold data and drop valid.
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (rd_acc) begin
          rd_data_q  <= mem[rd_ptr_q];
          rd_valid_q <= 1'b1;
        end else begin
          rd_valid_q <= 1'b0;
        end
      end

      assign rd_data_o  = rd_data_q;
      assign rd_valid_o = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo at DEPTH=6: one FWFT instance and one registered-read instance share the same stimulus.
// Directed table and hand sequences cover the corner cases; a random phase is checked against a queue model.
// Every step drives inputs just after a rising edge and samples outputs 1ns after the following edge.
module tb_sync_fifo;

  localparam int D  = 6;
  localparam int DW = 8;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic rd_en = 1'b0;
  logic flush = 1'b0;
  logic clr_err = 1'b0;

  logic full1, af1, vld1, e1, ne1, ae1, ovf1, unf1;
  logic [DW-1:0] dat1;
  logic [PW:0] cnt1;
  logic full0, af0, vld0, e0, ne0, ae0, ovf0, unf0;
  logic [DW-1:0] dat0;
  logic [PW:0] cnt0;

  always #5 clk = ~clk;

  sync_fifo #(.DEPTH(D), .DATA_WIDTH(DW), .PTR_WIDTH(PW), .AF_LEVEL(5), .AE_LEVEL(1), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_i(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full1), .almost_full_o(af1), .rd_en_i(rd_en), .rd_data_o(dat1), .rd_valid_o(vld1),
    .empty_o(e1), .not_empty_o(ne1), .almost_empty_o(ae1), .count_o(cnt1), .flush_i(flush),
    .overflow_o(ovf1), .underflow_o(unf1), .clr_err_i(clr_err)
  );

  sync_fifo #(.DEPTH(D), .DATA_WIDTH(DW), .PTR_WIDTH(PW), .AF_LEVEL(5), .AE_LEVEL(1), .FWFT(0)) u_reg (
    .clk_i(clk), .rst_i(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full0), .almost_full_o(af0), .rd_en_i(rd_en), .rd_data_o(dat0), .rd_valid_o(vld0),
    .empty_o(e0), .not_empty_o(ne0), .almost_empty_o(ae0), .count_o(cnt0), .flush_i(flush),
    .overflow_o(ovf0), .underflow_o(unf0), .clr_err_i(clr_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents as a plain queue plus the flag and registered-read state.
  logic [DW-1:0] mq[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  logic m_v0  = 1'b0;
  logic [DW-1:0] m_d0 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic w, input logic [DW-1:0] d,
                              input logic rd, input logic fl, input logic cl);
    bit is_full, is_empty, rd_ok, wr_ok;
    if (!r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_v0  = 1'b0;
      m_d0  = '0;
      return;
    end
    is_full  = (mq.size() == D);
    is_empty = (mq.size() == 0);
    m_ovf = (w && is_full && !rd) || (m_ovf && !cl);
    m_unf = (rd && is_empty) || (m_unf && !cl);
    if (fl) begin
      mq.delete();
      m_v0 = 1'b0;
    end else begin
      rd_ok = rd && !is_empty;
      wr_ok = w && !is_full;
      if (rd_ok) begin
        m_d0 = mq.pop_front();
        m_v0 = 1'b1;
      end else begin
        m_v0 = 1'b0;
      end
      if (wr_ok) mq.push_back(d);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("count_fwft", 32'(cnt1), n);
    chk("count_reg",  32'(cnt0), n);
    chk("full",       32'(full1), 32'(n == D));
    chk("full_reg",   32'(full0), 32'(n == D));
    chk("almost_full", 32'(af1), 32'(n >= 5));
    chk("empty",      32'(e1), 32'(n == 0));
    chk("empty_reg",  32'(e0), 32'(n == 0));
    chk("not_empty",  32'(ne1), 32'(n != 0));
    chk("almost_empty", 32'(ae1), 32'(n <= 1));
    chk("almost_full_reg", 32'(af0), 32'(n >= 5));
    chk("almost_empty_reg", 32'(ae0), 32'(n <= 1));
    chk("not_empty_reg", 32'(ne0), 32'(n != 0));
    chk("overflow",   32'(ovf1), 32'(m_ovf));
    chk("underflow",  32'(unf1), 32'(m_unf));
    chk("overflow_reg",  32'(ovf0), 32'(m_ovf));
    chk("underflow_reg", 32'(unf0), 32'(m_unf));
    chk("valid_fwft", 32'(vld1), 32'(n != 0));
    if (n != 0) chk("data_fwft", 32'(dat1), 32'(mq[0]));
    chk("valid_reg",  32'(vld0), 32'(m_v0));
    chk("data_reg",   32'(dat0), 32'(m_d0));
  endtask

  task automatic step(input logic r, input logic w, input logic [DW-1:0] d,
                      input logic rd, input logic fl, input logic cl);
    rst_n = r; wr_en = w; wr_data = d; rd_en = rd; flush = fl; clr_err = cl;
    @(posedge clk);
    model_update(r, w, d, rd, fl, cl);
    #1;
    check_model();
  endtask

  typedef struct {
    logic r; logic w; logic [DW-1:0] d; logic rd; logic fl; logic cl;
    int cnt; logic full; logic af; logic empty; logic ovf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int phase;
    logic [31:0] exp_d;

    // Fill-to-overflow table: reset, six writes 0x10..0x15, a rejected seventh write, then idle.
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 1; i <= 6; i++)
      tbl[i] = '{1'b1, 1'b1, 8'(16 + i - 1), 1'b0, 1'b0, 1'b0, i, (i == 6), (i >= 5), 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 8'h16, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b1, 1'b0, 1'b1};

    for (int k = 0; k < 9; k++) begin
      step(tbl[k].r, tbl[k].w, tbl[k].d, tbl[k].rd, tbl[k].fl, tbl[k].cl);
      chk("tbl_count", 32'(cnt1), tbl[k].cnt);
      chk("tbl_full",  32'(full1), 32'(tbl[k].full));
      chk("tbl_afull", 32'(af1), 32'(tbl[k].af));
      chk("tbl_empty", 32'(e1), 32'(tbl[k].empty));
      chk("tbl_ovf",   32'(ovf1), 32'(tbl[k].ovf));
    end

    // Drain in order, then an extra read and an error clear.
    for (int i = 0; i < 6; i++) begin
      chk("drain_head_fwft", 32'(dat1), 32'(16 + i));
      step(1, 0, 0, 1, 0, 0);
      chk("drain_data_reg", 32'(dat0), 32'(16 + i));
      chk("drain_valid_reg", 32'(vld0), 1);
    end
    chk("drained_empty", 32'(e1), 1);
    step(1, 0, 0, 1, 0, 0);
    chk("underflow_set", 32'(unf1), 1);
    chk("overflow_held", 32'(ovf1), 1);
    chk("underflow_no_valid", 32'(vld0), 0);
    step(1, 0, 0, 0, 0, 1);
    chk("clr_ovf", 32'(ovf1), 0);
    chk("clr_unf", 32'(unf1), 0);

    // Wrap: hold occupancy at 3 while pushing 20 write/read pairs through.
    for (int i = 0; i < 3; i++) step(1, 1, 8'(32 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 8'(48 + i), 1, 0, 0);
      exp_d = (i < 3) ? 32'(32 + i) : 32'(48 + i - 3);
      chk("wrap_data", 32'(dat0), exp_d);
      chk("wrap_count", 32'(cnt1), 3);
    end

    // Simultaneous write+read at full, then at empty.
    for (int i = 0; i < 3; i++) step(1, 1, 8'(64 + i), 0, 0, 0);
    chk("refill_full", 32'(full1), 1);
    step(1, 1, 8'h50, 1, 0, 0);
    chk("full_wr_rd_count", 32'(cnt1), 5);
    chk("full_wr_rd_no_ovf", 32'(ovf1), 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 0);
    step(1, 1, 8'h60, 1, 0, 0);
    chk("empty_wr_rd_count", 32'(cnt1), 1);
    chk("empty_wr_rd_no_valid", 32'(vld0), 0);
    step(1, 0, 0, 1, 0, 1);

    // Registered read: data and valid appear exactly one cycle after the read request.
    step(1, 1, 8'hA5, 0, 0, 0);
    chk("a5_no_valid_on_write", 32'(vld0), 0);
    step(1, 0, 0, 1, 0, 0);
    chk("a5_valid", 32'(vld0), 1);
    chk("a5_data", 32'(dat0), 32'hA5);
    step(1, 0, 0, 0, 0, 0);
    chk("a5_valid_pulse", 32'(vld0), 0);
    chk("a5_data_hold", 32'(dat0), 32'hA5);

    // Flush with a concurrent write, then reset in the middle of traffic.
    for (int i = 0; i < 4; i++) step(1, 1, 8'(112 + i), 0, 0, 0);
    step(1, 1, 8'h99, 0, 1, 0);
    chk("flush_count", 32'(cnt1), 0);
    chk("flush_empty", 32'(e1), 1);
    step(1, 0, 0, 1, 0, 0);
    chk("flush_write_dropped", 32'(cnt1), 0);
    chk("flush_unf", 32'(unf1), 1);
    for (int i = 0; i < 3; i++) step(1, 1, 8'(128 + i), 1, 0, 0);
    step(0, 1, 8'h55, 1, 1, 0);
    chk("rst_count", 32'(cnt1), 0);
    chk("rst_empty", 32'(e1), 1);
    chk("rst_aempty", 32'(ae1), 1);
    chk("rst_full", 32'(full1), 0);
    chk("rst_afull", 32'(af1), 0);
    chk("rst_unf", 32'(unf1), 0);
    chk("rst_ovf", 32'(ovf1), 0);
    chk("rst_valid_reg", 32'(vld0), 0);
    chk("rst_data_reg", 32'(dat0), 0);
    chk("rst_valid_fwft", 32'(vld1), 0);

    // Random traffic in phases biased toward filling or draining.
    phase = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) phase = $urandom_range(0, 2);
      step($urandom_range(0, 149) != 0,
           (phase == 0) ? ($urandom_range(0, 3) != 0) : (phase == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)),
           8'($urandom),
           (phase == 1) ? ($urandom_range(0, 3) != 0) : (phase == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)),
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 24) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
